// File: rtl/aes_enc_iter.sv
// Iterative AES encryption core (AES-128 / AES-256), one round per clock.
// The key schedule is expanded on the fly alongside the rounds.
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid / in_ready       input handshake for in_data (plaintext) + in_key
//   in_data[128]              plaintext, [127:120] is byte 0
//   in_key[KEY_BITS]          cipher key, [KEY_BITS-1 -: 8] is key byte 0
//   out_valid / out_ready     output handshake for out_data (ciphertext)
//   out_data[128]             ciphertext, held until the next completion
//   busy                      high while rounds are in progress
module aes_enc_iter #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);

  localparam int unsigned NR = (KEY_BITS == 256) ? 14 : 10;

  if ((KEY_BITS != 128) && (KEY_BITS != 256)) begin : g_bad_key_bits
    $error("aes_enc_iter: KEY_BITS must be 128 or 256");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_e;

  // GF(2^8) helpers; the S-box is computed as x^254 followed by the affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0: return 8'h01;
      4'd1: return 8'h02;
      4'd2: return 8'h04;
      4'd3: return 8'h08;
      4'd4: return 8'h10;
      4'd5: return 8'h20;
      4'd6: return 8'h40;
      4'd7: return 8'h80;
      4'd8: return 8'h1b;
      4'd9: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Next 128-bit round key: base is the key Nk words back, last is the preceding word.
  function automatic logic [127:0] key_step(input logic [127:0] base, input logic [31:0] last,
                                            input logic [7:0] rc, input logic rot);
    logic [31:0] t, w0, w1, w2, w3;
    t  = rot ? (sub_word({last[23:0], last[31:24]}) ^ {rc, 24'h000000}) : sub_word(last);
    w0 = base[127:96] ^ t;
    w1 = base[95:64]  ^ w0;
    w2 = base[63:32]  ^ w1;
    w3 = base[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // One cipher round; byte k sits at row k%4, column k/4.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b  [16];
    logic [7:0]   sh [16];
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int k = 0; k < 16; k++) b[k] = sbox(s[127-8*k -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) sh[r+4*c] = b[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = sh[4*c]; a1 = sh[4*c+1]; a2 = sh[4*c+2]; a3 = sh[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ rk;
  endfunction

  fsm_e                fsm_q, fsm_d;
  logic [127:0]        state_q, state_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [3:0]          round_q, round_d;
  logic [127:0]        out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic [127:0]        rk_cur;
  logic [KEY_BITS-1:0] key_adv;
  logic [127:0]        round_out;
  logic                last_round;
  logic                accept;

  // AES-128 keeps the previous round key; AES-256 keeps the two most recent ones.
  if (KEY_BITS == 256) begin : g_k256
    always_comb begin
      rk_cur  = key_q[127:0];
      key_adv = {key_q[127:0],
                 key_step(key_q[255:128], key_q[31:0], rcon(round_q >> 1), round_q[0])};
    end
  end else begin : g_k128
    always_comb begin
      rk_cur  = key_step(key_q[127:0], key_q[31:0], rcon(4'(round_q - 4'd1)), 1'b1);
      key_adv = rk_cur;
    end
  end

  assign last_round = (round_q == 4'(NR));
  assign round_out  = aes_round(state_q, rk_cur, last_round);
  assign in_ready   = ~rst & ((fsm_q == S_IDLE) | ((fsm_q == S_DONE) & out_ready));
  assign accept     = in_valid & in_ready;

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      key_q       <= '0;
      round_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      key_q       <= key_d;
      round_q     <= round_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:  if (accept) fsm_d = S_ROUND;
      S_ROUND: if (last_round) fsm_d = S_DONE;
      S_DONE:  if (out_ready) fsm_d = accept ? S_ROUND : S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    round_d     = round_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (fsm_q)
      S_ROUND: begin
        state_d = round_out;
        key_d   = key_adv;
        round_d = round_q + 4'd1;
        if (last_round) begin
          round_d     = 4'd0;
          out_data_d  = round_out;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      S_DONE: if (out_ready) out_valid_d = 1'b0;
      default: ;
    endcase
    // Initial AddRoundKey happens at capture.
    if (accept) begin
      state_d = in_data ^ in_key[KEY_BITS-1 -: 128];
      key_d   = in_key;
      round_d = 4'd1;
      busy_d  = 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule
